ttl_74190: RTL and testbench

- Synchronous 4-bit BCD decade up/down counter with parallel load, count enable, Max/Min and ripple-clock outputs.
- Companion to the team's up-only decade counter. Adds the down-counting direction so multi-digit BCD chains can count toward zero (timers, countdown presets).
- Cascadable: RCO_bar of one digit drives Enable_bar of the next.
- Deviations from the physical chip: Clear is added, and Load_bar is synchronous.

---
 rtl/ttl_74190_pkg.sv | 39 +++
 rtl/ttl_74190_bcd_step.sv | 40 ++++
 rtl/ttl_74190.sv | 90 +++++++++
 tb/tb_ttl_74190.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ttl_74190_pkg.sv
// -----------------------------------------------------------------------------
// ttl_74190_pkg
// Shared definitions for the BCD decade counter parts.
//   - BCD range limits (BCD_MAX / BCD_MIN)
//   - Where each abnormal state (1010..1111) goes after one step
//   - Count direction enum matching the Down_Up pin encoding
//   - Helpers: is_bcd() and is_terminal()
// -----------------------------------------------------------------------------
package ttl_74190_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'b1001;
  localparam logic [3:0]  BCD_MIN = 4'b0000;

  // Up-count recovery. These match the up-only decade counter so that both
  // parts recover identically from a bad load.
  localparam logic [3:0]  UP_RECOVER_EVEN = 4'b1001;  // from 1010, 1100, 1110
  localparam logic [3:0]  UP_RECOVER_1011 = 4'b0100;  // from 1011
  localparam logic [3:0]  UP_RECOVER_ODD  = 4'b0000;  // from 1101, 1111

  // Down-count recovery. Every abnormal state returns to 9 in a single step.
  localparam logic [3:0]  DOWN_RECOVER    = 4'b1001;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic is_bcd(input logic [3:0] v);
    return v <= BCD_MAX;
  endfunction

  // True when the digit wraps on the next step in the given direction.
  // Abnormal states are never terminal.
  function automatic logic is_terminal(input logic [3:0] q, input dir_e dir);
    return (dir == DIR_UP) ? (q == BCD_MAX) : (q == BCD_MIN);
  endfunction

endpackage

// File: rtl/ttl_74190_bcd_step.sv
// -----------------------------------------------------------------------------
// ttl_74190_bcd_step
// Combinational next-digit function for one BCD decade, in either direction.
// It includes recovery from the abnormal states 1010..1111.
//   q_i      : current digit value
//   dir_i    : DIR_UP or DIR_DOWN
//   q_next_o : digit value after one count step
// -----------------------------------------------------------------------------
module ttl_74190_bcd_step
  import ttl_74190_pkg::*;
(
  input  logic [3:0] q_i,
  input  dir_e       dir_i,
  output logic [3:0] q_next_o
);

  always_comb begin
    // NOTE: assign a default before any branch. Without it, a path that
    // misses an assignment would infer a latch instead of pure logic.
    q_next_o = q_i;
    if (dir_i == DIR_UP) begin
      unique case (q_i)
        4'b1001:                   q_next_o = BCD_MIN;
        4'b1010, 4'b1100, 4'b1110: q_next_o = UP_RECOVER_EVEN;
        4'b1011:                   q_next_o = UP_RECOVER_1011;
        4'b1101, 4'b1111:          q_next_o = UP_RECOVER_ODD;
        default:                   q_next_o = q_i + 4'd1;
      endcase
    end else begin
      if (!is_bcd(q_i)) begin
        q_next_o = DOWN_RECOVER;
      end else if (q_i == BCD_MIN) begin
        q_next_o = BCD_MAX;
      end else begin
        q_next_o = q_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/ttl_74190.sv
// -----------------------------------------------------------------------------
// ttl_74190
// Synchronous 4-bit BCD decade up/down counter. It has a synchronous clear,
// a synchronous parallel load, a count enable, and Max/Min and ripple-clock
// outputs. To cascade digits, connect RCO_bar of one digit to Enable_bar of
// the next.
// Ports:
//   Clk        : rising-edge clock
//   Clear      : synchronous active-high clear (Q <= 0), highest priority
//   Load_bar   : synchronous active-low parallel load of D
//   Enable_bar : active-low count enable
//   Down_Up    : 1 = count down, 0 = count up
//   D          : parallel load data
//   Q          : counter value
//   Max_Min    : terminal count for the current direction (9 up, 0 down)
//   RCO_bar    : active-low ripple clock, low during Clk-low before a wrap
// Only WIDTH = 4 is meaningful. BCD has no definition for other widths.
// -----------------------------------------------------------------------------
module ttl_74190
  import ttl_74190_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Load_bar,
  input  logic             Enable_bar,
  input  logic             Down_Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Max_Min,
  output logic             RCO_bar
);

  dir_e             dir;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_step;
  logic             max_min;
  logic             rco_bar;

  assign dir = dir_e'(Down_Up);

  ttl_74190_bcd_step u_step (
    .q_i      (q_q),
    .dir_i    (dir),
    .q_next_o (q_step)
  );

  // Load takes priority over count. Clear is applied in the register itself.
  always_comb begin
    q_d = q_q;
    if (!Load_bar) begin
      q_d = D;
    end else if (!Enable_bar) begin
      q_d = q_step;
    end
  end

  // NOTE: state registers use non-blocking assignment. This lets every flop
  // sample the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Max_Min follows a Down_Up change at once, with no clock edge needed.
  // RCO_bar is gated by Clk-low on purpose. This keeps the chip's
  // ripple-clock behaviour for cascaded digits.
  assign max_min = is_terminal(q_q, dir);
  assign rco_bar = ~(max_min & ~Enable_bar & ~Clk);

  generate
    if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_no_delay
      assign Q       = q_q;
      assign Max_Min = max_min;
      assign RCO_bar = rco_bar;
    end else begin : g_delay
      assign #(DELAY_RISE, DELAY_FALL) Q       = q_q;
      assign #(DELAY_RISE, DELAY_FALL) Max_Min = max_min;
      assign #(DELAY_RISE, DELAY_FALL) RCO_bar = rco_bar;
    end
  endgenerate

endmodule

// File: tb/tb_ttl_74190.sv
// -----------------------------------------------------------------------------
// tb_ttl_74190
// Directed, table-driven bench for ttl_74190. A second instance acts as the
// tens digit of a two-digit down-counting cascade.
// -----------------------------------------------------------------------------
module tb_ttl_74190;

  logic       Clk = 1'b0;
  logic       Clear = 1'b0;
  logic       Load_bar = 1'b1;
  logic       Enable_bar = 1'b1;
  logic       Down_Up = 1'b0;
  logic [3:0] D = 4'd0;
  logic [3:0] Q;
  logic       Max_Min;
  logic       RCO_bar;

  logic [3:0] tens_d = 4'd0;
  logic       tens_en_bar = 1'b1;
  logic [3:0] tens_q;
  logic       tens_mm;
  logic       tens_rco_bar;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  ttl_74190 dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .Load_bar   (Load_bar),
    .Enable_bar (Enable_bar),
    .Down_Up    (Down_Up),
    .D          (D),
    .Q          (Q),
    .Max_Min    (Max_Min),
    .RCO_bar    (RCO_bar)
  );

  ttl_74190 u_tens (
    .Clk        (Clk),
    .Clear      (Clear),
    .Load_bar   (Load_bar),
    .Enable_bar (tens_en_bar),
    .Down_Up    (Down_Up),
    .D          (tens_d),
    .Q          (tens_q),
    .Max_Min    (tens_mm),
    .RCO_bar    (tens_rco_bar)
  );

  // The ones digit's RCO_bar is sampled in the middle of Clk-low and held
  // across the rising edge. Feeding it straight through with zero delay
  // would race against that edge.
  always @(negedge Clk) begin
    #2;
    tens_en_bar = RCO_bar;
  end

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // One clock cycle. Inputs are driven at the falling edge. Max_Min/RCO_bar
  // are sampled in the low phase (pre); Q/Max_Min/RCO_bar are sampled just
  // after the rising edge (post).
  task automatic step(input logic clr, input logic ld_n, input logic en_n,
                      input logic dn, input logic [3:0] d,
                      output logic mm_pre, output logic rco_pre,
                      output logic [3:0] q, output logic mm, output logic rco_hi);
    @(negedge Clk);
    Clear = clr; Load_bar = ld_n; Enable_bar = en_n; Down_Up = dn; D = d;
    #1;
    mm_pre  = Max_Min;
    rco_pre = RCO_bar;
    @(posedge Clk);
    #1;
    q      = Q;
    mm     = Max_Min;
    rco_hi = RCO_bar;
  endtask

  typedef struct {
    logic       clr;
    logic       ld_n;
    logic       en_n;
    logic       dn;
    logic [3:0] d;
    logic       mm_pre;   // Max_Min in the low phase before the edge
    logic       rco_pre;  // RCO_bar in the low phase before the edge
    logic [3:0] q;        // Q after the edge
    logic       mm;       // Max_Min after the edge
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic       mp, rp, m, rh;
    logic [3:0] q;
    logic [3:0] up_exp [6];
    int         n;

    // Initial clear (up direction): Q = 0 and Max_Min = 0.
    step(1, 1, 1, 0, 4'd0, mp, rp, q, m, rh);
    check("clear_q", q, 4'd0);
    check("clear_mm", {3'b0, m}, 4'd0);

    //          clr ld en dn  d      mmp rco  q      mm
    // Up-count for 12 edges starting at 0.
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd1, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd2, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd3, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd4, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd5, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd6, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd7, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd8, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd9, 1});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 1, 0, 4'd0, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd1, 0});
    vecs.push_back('{0, 1, 0, 0, 4'd0, 0, 1, 4'd2, 0});
    // Load 3 (with down selected), then count down 5 edges.
    vecs.push_back('{0, 0, 0, 1, 4'd3, 0, 1, 4'd3, 0});
    vecs.push_back('{0, 1, 0, 1, 4'd0, 0, 1, 4'd2, 0});
    vecs.push_back('{0, 1, 0, 1, 4'd0, 0, 1, 4'd1, 0});
    vecs.push_back('{0, 1, 0, 1, 4'd0, 0, 1, 4'd0, 1});
    vecs.push_back('{0, 1, 0, 1, 4'd0, 1, 0, 4'd9, 0});
    vecs.push_back('{0, 1, 0, 1, 4'd0, 0, 1, 4'd8, 0});
    // Priority: Clear beats load and count. Load beats count.
    vecs.push_back('{1, 0, 0, 0, 4'd7, 0, 1, 4'd0, 0});
    vecs.push_back('{0, 0, 0, 0, 4'd5, 0, 1, 4'd5, 0});
    vecs.push_back('{0, 0, 0, 0, 4'd2, 0, 1, 4'd2, 0});
    // Load 9, hold for 3 edges with the enable off (RCO_bar stays high).
    vecs.push_back('{0, 0, 1, 0, 4'd9, 0, 1, 4'd9, 1});
    vecs.push_back('{0, 1, 1, 0, 4'd0, 1, 1, 4'd9, 1});
    vecs.push_back('{0, 1, 1, 0, 4'd0, 1, 1, 4'd9, 1});
    vecs.push_back('{0, 1, 1, 0, 4'd0, 1, 1, 4'd9, 1});
    // Switch to down at Q=9: Max_Min drops before the edge, then Q=8.
    vecs.push_back('{0, 1, 0, 1, 4'd0, 0, 1, 4'd8, 0});
    // Clear with down selected: Q=0 and Max_Min=1.
    vecs.push_back('{1, 1, 1, 1, 4'd0, 0, 1, 4'd0, 1});

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld_n, vecs[i].en_n, vecs[i].dn, vecs[i].d,
           mp, rp, q, m, rh);
      check($sformatf("v%0d_mm_pre", i), {3'b0, mp}, {3'b0, vecs[i].mm_pre});
      check($sformatf("v%0d_rco_pre", i), {3'b0, rp}, {3'b0, vecs[i].rco_pre});
      check($sformatf("v%0d_q", i), q, vecs[i].q);
      check($sformatf("v%0d_mm", i), {3'b0, m}, {3'b0, vecs[i].mm});
      check($sformatf("v%0d_rco_clk_hi", i), {3'b0, rh}, 4'd1);
    end

    // Abnormal loads 1010..1111: one up step, then reload and one down step.
    up_exp[0] = 4'b1001; up_exp[1] = 4'b0100; up_exp[2] = 4'b1001;
    up_exp[3] = 4'b0000; up_exp[4] = 4'b1001; up_exp[5] = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] v;
      v = 4'(10 + k);
      step(0, 0, 1, 0, v, mp, rp, q, m, rh);
      check($sformatf("ab%0d_load_q", k), q, v);
      check($sformatf("ab%0d_load_mm_up", k), {3'b0, m}, 4'd0);
      step(0, 1, 0, 0, 4'd0, mp, rp, q, m, rh);
      check($sformatf("ab%0d_up_mm_pre", k), {3'b0, mp}, 4'd0);
      check($sformatf("ab%0d_up_rco_pre", k), {3'b0, rp}, 4'd1);
      check($sformatf("ab%0d_up_q", k), q, up_exp[k]);
      step(0, 0, 1, 1, v, mp, rp, q, m, rh);
      check($sformatf("ab%0d_reload_mm_dn", k), {3'b0, m}, 4'd0);
      step(0, 1, 0, 1, 4'd0, mp, rp, q, m, rh);
      check($sformatf("ab%0d_dn_mm_pre", k), {3'b0, mp}, 4'd0);
      check($sformatf("ab%0d_dn_q", k), q, 4'b1001);
    end

    // Two-digit cascade counting down from 20 through 00 to 99.
    tens_d = 4'd2;
    step(0, 0, 1, 1, 4'd0, mp, rp, q, m, rh);
    check("cas_load_ones", q, 4'd0);
    check("cas_load_tens", tens_q, 4'd2);
    n = 20;
    for (int k = 1; k <= 21; k++) begin
      n = (n + 99) % 100;
      step(0, 1, 0, 1, 4'd0, mp, rp, q, m, rh);
      check($sformatf("cas%0d_ones", k), q, 4'(n % 10));
      check($sformatf("cas%0d_tens", k), tens_q, 4'(n / 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
